// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the serializer.
// Frames are sent back to back while the FIFO holds data, so a burst leaves as one packet.
module uart_tx #(
  parameter int ClkFrequency = 12000000,
  parameter int Baud         = 2000000,
  parameter int FifoDepth    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [$clog2(FifoDepth):0]   fifo_level,
  output logic                         TxD,
  output logic                         TxD_busy
);

  localparam int BitClks = ClkFrequency / Baud;
  localparam int CntW    = (BitClks > 1) ? $clog2(BitClks) : 1;
  localparam int AddrW   = $clog2(FifoDepth);

  localparam logic [CntW-1:0]  CntLast   = CntW'(BitClks - 1);
  localparam logic [AddrW:0]   LevelFull = (AddrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]    level_q, level_d;
  logic [7:0]        mem_q [FifoDepth];

  logic              push;
  logic              pop;
  logic              cnt_last;
  logic              fifo_nonempty;
  logic [7:0]        head;

  // Full blocks writes even when a pop happens in the same cycle.
  assign tx_ready      = (level_q != LevelFull);
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (level_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign cnt_last      = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit so bursts have no idle gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AddrW'(push);
    rd_ptr_d = rd_ptr_q + AddrW'(pop);
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + (AddrW + 1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign fifo_level = level_q;
  assign TxD        = txd_q;
  assign TxD_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-time reference model checked every cycle,
// a short vector table, directed corner sequences and a randomized push phase.
module tb_uart_tx;

  localparam int ClkHz    = 12000000;
  localparam int BaudRate = 2000000;
  localparam int Depth    = 16;
  localparam int B        = ClkHz / BaudRate;
  localparam int FRAME    = 10 * B;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] fifo_level;
  logic       TxD;
  logic       TxD_busy;

  uart_tx #(
    .ClkFrequency(ClkHz),
    .Baud(BaudRate),
    .FifoDepth(Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .fifo_level(fifo_level),
    .TxD(TxD),
    .TxD_busy(TxD_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, plus the position inside the frame being sent.
  logic [7:0] m_q[$];
  logic       m_busy = 1'b0;
  int         m_pos  = 0;
  logic [7:0] m_cur  = 8'h00;

  logic       cap[$];
  logic       cap_on = 1'b0;
  logic [7:0] exp_bytes[$];

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_txd;
    logic       e_busy;
    int         e_level;
    logic       e_ready;
  } vec_t;

  vec_t vecs[10];
  logic exp2[20];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level from the frame position: slot 0 start, slots 1..8 data LSB first, slot 9 stop.
  function automatic logic model_txd();
    int slot;
    if (!m_busy) return 1'b1;
    slot = m_pos / B;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
    return 1'b1;
  endfunction

  task automatic modelEdge(input logic r, input logic v, input logic [7:0] d);
    int   pre;
    logic do_pop;
    pre    = m_q.size();
    do_pop = 1'b0;
    if (r) begin
      m_q.delete();
      m_busy = 1'b0;
      m_pos  = 0;
      return;
    end
    if (!m_busy) begin
      do_pop = (pre > 0);
    end else if (m_pos == FRAME - 1) begin
      if (pre > 0) do_pop = 1'b1;
      else m_busy = 1'b0;
    end else begin
      m_pos++;
    end
    if (do_pop) begin
      m_cur  = m_q.pop_front();
      m_busy = 1'b1;
      m_pos  = 0;
    end
    if (v && pre < Depth) m_q.push_back(d);
  endtask

  task automatic checkOutput();
    cmp("txd", TxD, model_txd());
    cmp("busy", TxD_busy, m_busy);
    cmp("level", fifo_level, m_q.size());
    cmp("ready", tx_ready, (m_q.size() < Depth));
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    rst      = r;
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    modelEdge(r, v, d);
    @(negedge clk);
    checkOutput();
    if (cap_on && TxD_busy) cap.push_back(TxD);
  endtask

  task automatic runUntilIdle(input int limit);
    int n;
    n = 0;
    while ((TxD_busy || fifo_level != 0) && n < limit) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (n >= limit) cmp("idle_timeout", n, 0);
  endtask

  // Decode captured busy-cycle samples mid-bit into frames and compare with expected bytes.
  task automatic checkFrames(input string name);
    logic [9:0] got;
    cmp({name, "_len"}, cap.size(), FRAME * exp_bytes.size());
    foreach (exp_bytes[j]) begin
      if (cap.size() >= (j + 1) * FRAME) begin
        for (int k = 0; k < 10; k++) got[k] = cap[j*FRAME + k*B + B/2];
        cmp(name, got, {1'b1, exp_bytes[j], 1'b0});
      end
    end
  endtask

  initial begin
    int         n;
    int         quiet;
    logic [7:0] rb;
    logic       rv;
    logic       rr;
    int         phase_pct[3];

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1};

    exp2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset, then a single 0x55 frame.
    cap.delete();
    cap_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].d);
      cmp("vec_txd", TxD, vecs[i].e_txd);
      cmp("vec_busy", TxD_busy, vecs[i].e_busy);
      cmp("vec_level", fifo_level, vecs[i].e_level);
      cmp("vec_ready", tx_ready, vecs[i].e_ready);
    end
    runUntilIdle(200);
    exp_bytes.delete();
    exp_bytes.push_back(8'h55);
    checkFrames("frame55");

    // Two consecutive pushes: contiguous 20-bit line pattern.
    cap.delete();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    runUntilIdle(400);
    cmp("pair_len", cap.size(), 2 * FRAME);
    for (int j = 0; j < 2 * FRAME; j++) begin
      if (j < cap.size()) cmp("pair_bit", cap[j], exp2[j/B]);
    end

    // Eighteen back-to-back pushes: the FIFO fills and the last byte is dropped.
    cap.delete();
    exp_bytes.delete();
    for (int i = 0; i < 18; i++) begin
      if (i == 17) begin
        cmp("burst_ready", tx_ready, 1'b0);
        cmp("burst_level", fifo_level, Depth);
      end
      rb = 8'($urandom);
      if (i < 17) exp_bytes.push_back(rb);
      applyStimulus(1'b0, 1'b1, rb);
    end
    runUntilIdle(2000);
    checkFrames("burst");

    // Push landing on the same edge as the end-of-stop pop.
    cap.delete();
    exp_bytes.delete();
    exp_bytes.push_back(8'h81);
    exp_bytes.push_back(8'h42);
    exp_bytes.push_back(8'hE7);
    applyStimulus(1'b0, 1'b1, 8'h81);
    applyStimulus(1'b0, 1'b1, 8'h42);
    n = 0;
    while (!(m_busy && m_pos == FRAME - 1) && n < 200) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (n >= 200) cmp("stop_wait_timeout", n, 0);
    applyStimulus(1'b0, 1'b1, 8'hE7);
    cmp("stop_pop_level", fifo_level, 1);
    runUntilIdle(400);
    checkFrames("stop_pop");

    // Reset in the middle of data bit 3 of 0xF0 with two bytes queued.
    cap_on = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'hF0);
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    n = 0;
    while (m_pos != 4 * B + 2 && n < 100) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (n >= 100) cmp("bit3_wait_timeout", n, 0);
    cmp("pre_rst_level", fifo_level, 2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    cmp("rst_txd", TxD, 1'b1);
    cmp("rst_busy", TxD_busy, 1'b0);
    cmp("rst_level", fifo_level, 0);
    quiet = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (TxD_busy || !TxD) quiet++;
    end
    cmp("rst_quiet", quiet, 0);
    cap.delete();
    cap_on = 1'b1;
    exp_bytes.delete();
    exp_bytes.push_back(8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    runUntilIdle(200);
    checkFrames("after_rst");

    // Randomized traffic at light, medium and saturating push rates.
    cap_on = 1'b0;
    phase_pct = '{15, 50, 97};
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 800; i++) begin
        rv = ($urandom_range(0, 99) < phase_pct[p]);
        rr = ($urandom_range(0, 599) == 0);
        rb = 8'($urandom);
        applyStimulus(rr, rv, rb);
      end
    end
    runUntilIdle(2000);

    tx_valid = 1'b0;
    rst      = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter, 8N1 framing, LSB first, idle-high line.
- Companion to the design's UART receiver; same ClkFrequency/Baud parameterisation, so both ends of a link agree on bit timing.
- Includes a small byte FIFO so firmware-side logic can push bursts with a valid/ready handshake while the serializer drains at line rate.
- Back-to-back frames are sent with no idle gap, so a burst arrives at the receiver as one packet.

Parameters:
- ClkFrequency, 12000000: clk frequency in Hz.
- Baud, 2000000: line rate in bit/s.
- FifoDepth, 16: FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; combinational: !full.
- fifo_level  output  clog2(FifoDepth)+1  bytes currently queued (excludes the byte in the shifter).
- TxD  output  1  serial line, registered.
- TxD_busy  output  1  frame in progress (state != IDLE), registered.

Behaviour:
- Reset values:
  - Clocked on clk; rst is synchronous and active-high.
  - rst high at a posedge sets: TxD=1, TxD_busy=0, fifo_level=0, tx_ready=1, state=IDLE, bit and baud counters=0.
  - rst overrides everything, including a frame mid-transmission. The line goes high at that edge, the FIFO contents are discarded, and no partial frame resumes.
- Bit timing:
  - BitClks = ClkFrequency/Baud (integer division); BitClks must be ≥2. Defaults give 6.
  - A baud counter counts 0..BitClks-1 and resets on each state entry.
  - Every line bit is held exactly BitClks clocks.
- FIFO:
  - A push occurs when tx_valid && tx_ready at a posedge.
  - When tx_ready=0, tx_valid is ignored and the byte is dropped; it is not held.
  - A pop occurs when the FSM loads the shifter.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - When full, tx_ready=0 even if a pop happens that cycle; a concurrent pop does not admit a write.
  - Read/write pointers wrap modulo FifoDepth. fifo_level ranges 0..FifoDepth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If fifo_level>0 at a posedge: pop the head into the shifter, go to START, drive TxD=0 at that same edge.
  - START: after BitClks clocks, go to DATA with bit index 0 and TxD=shifter[0].
  - DATA: every BitClks clocks, shift right and increment the bit index. After bit 7 completes, go to STOP with TxD=1.
  - STOP: lasts BitClks clocks. On the final cycle:
    - FIFO non-empty: pop and go directly to START (TxD=0 next edge). No idle cycle between frames.
    - FIFO empty: go to IDLE.
- Latency:
  - A byte pushed into an empty FIFO while IDLE at edge n is popped at edge n+1. TxD falls after edge n+1.
  - One frame = 10*BitClks clocks.
- TxD_busy=1 from the edge that enters START until the edge that returns to IDLE.
- A push to an empty FIFO while the FSM is busy is transmitted only after the current STOP completes.

Test Plan:
- Reset, then push 0x55 once while idle → TxD low one clock after the push edge, then holds each of 0,1,0,1,0,1,0,1,0,1 for 6 clocks. TxD_busy high 60 clocks, then TxD=1 and busy=0.
- Push 0xA5 then 0x3C on consecutive cycles → 120 contiguous clocks, line bits 0,1,0,1,0,0,1,0,1,1,0,0,0,1,1,1,1,0,0,1. No idle clock between the first stop bit and the second start bit.
- 18 consecutive pushes b0..b17 starting from idle → fifo_level reaches 16, tx_ready=0 on the 18th cycle, b17 dropped. The line carries exactly b0..b16 in order, and fifo_level returns to 0.
- Push on the same cycle the STOP-end pop occurs (FIFO level 1) → fifo_level stays 1. The popped byte is sent next, then the pushed byte.
- Assert rst during DATA bit 3 of 0xF0 with 2 bytes queued → TxD=1, busy=0, fifo_level=0 after that edge. No further frames. A subsequent push of 0x00 transmits cleanly.
